// File: rtl/ysyx_22050854_wb_arbiter.sv
// Write-back arbiter: buffers ALU/LSU results, drives the register-file write port, and tracks a busy scoreboard.
// Optional same-cycle read bypass is enabled by defining WB_BYPASS_EN.
module ysyx_22050854_wb_arbiter #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            issue_en,
  input  logic [4:0]      issue_rd,
  output logic [31:0]     busy,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]      byp_raddr,
  output logic            byp_hit,
  output logic [XLEN-1:0] byp_data
`endif
);

  localparam int unsigned CNT_W = 3;

  logic            alu_full, lsu_full;
  logic [4:0]      alu_rd_q, lsu_rd_q;
  logic [XLEN-1:0] alu_data_q, lsu_data_q;
  logic [CNT_W-1:0] starve_cnt;

  logic            grant_alu, grant_lsu;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;
  logic            wen_next;
  logic [31:0]     busy_next;

  // LSU has priority unless the waiting ALU entry has hit its starvation limit.
  always_comb begin
    grant_alu = alu_full & (~lsu_full | (starve_cnt == CNT_W'(STARVE_LIMIT)));
    grant_lsu = lsu_full & ~grant_alu;
    win_rd    = grant_alu ? alu_rd_q : lsu_rd_q;
    win_data  = grant_alu ? alu_data_q : lsu_data_q;
    wen_next  = (grant_alu | grant_lsu) & (win_rd != 5'd0);
  end

  assign alu_ready = ~alu_full | grant_alu;
  assign lsu_ready = ~lsu_full | grant_lsu;

  // A new issue to the same register outranks the completing write.
  always_comb begin
    busy_next = busy;
    if (wen_next) busy_next[win_rd] = 1'b0;
    if (issue_en && (issue_rd != 5'd0)) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alu_full   <= 1'b0;
      lsu_full   <= 1'b0;
      alu_rd_q   <= 5'd0;
      lsu_rd_q   <= 5'd0;
      alu_data_q <= '0;
      lsu_data_q <= '0;
      starve_cnt <= '0;
      busy       <= 32'd0;
      rf_wen     <= 1'b0;
      rf_waddr   <= 5'd0;
      rf_wdata   <= '0;
    end else begin
      if (alu_valid && alu_ready) begin
        alu_full   <= 1'b1;
        alu_rd_q   <= alu_rd;
        alu_data_q <= alu_data;
      end else if (grant_alu) begin
        alu_full <= 1'b0;
      end

      if (lsu_valid && lsu_ready) begin
        lsu_full   <= 1'b1;
        lsu_rd_q   <= lsu_rd;
        lsu_data_q <= lsu_data;
      end else if (grant_lsu) begin
        lsu_full <= 1'b0;
      end

      if (!alu_full || grant_alu) starve_cnt <= '0;
      else if (grant_lsu)         starve_cnt <= starve_cnt + CNT_W'(1);

      rf_wen <= wen_next;
      if (grant_alu || grant_lsu) begin
        rf_waddr <= win_rd;
        rf_wdata <= win_data;
      end

      busy <= busy_next;
    end
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    byp_hit  = rf_wen && (rf_waddr == byp_raddr) && (byp_raddr != 5'd0);
    byp_data = byp_hit ? rf_wdata : '0;
  end
`endif

endmodule
